// File: rtl/dds_mod_sequencer.sv
// Front-end sequencer for the DDS core: streams the sine LUT in after reset, then plays a
// stored modulation waveform into the frequency (FM) or amplitude (AM) control.
module dds_mod_sequencer #(
  parameter int unsigned LUT_AW   = 16,
  parameter int unsigned MOD_AW   = 8,
  parameter int unsigned FM_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mod_we,
  input  logic [MOD_AW-1:0] mod_addr,
  input  logic [15:0]       mod_data,
  input  logic              load_start,
  input  logic              lut_valid,
  input  logic [15:0]       lut_data,
  output logic              lut_ready,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic              loop,
  input  logic [31:0]       base_freq,
  input  logic [15:0]       hold_cycles,
  input  logic [MOD_AW:0]   num_samples,
  output logic              dds_en,
  output logic              dds_lut_we,
  output logic [31:0]       dds_lut_addr,
  output logic [31:0]       dds_lut_data,
  output logic [31:0]       dds_freq,
  output logic [15:0]       dds_ampl,
  output logic              lut_loaded,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IW = MOD_AW + 1;
  localparam logic [15:0] AmplFull = 16'h7FFF;

  typedef enum logic [2:0] {StIdle, StLoad, StFetch, StApply, StHold} state_e;

  state_e            state_q, state_d;
  logic [LUT_AW-1:0] lut_cnt_q, lut_cnt_d;
  logic              load_full_q, load_full_d;
  logic              lut_loaded_q, lut_loaded_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [15:0]       hold_cnt_q, hold_cnt_d;
  logic              fin_q, fin_d;
  logic [1:0]        mode_q, mode_d;
  logic [31:0]       base_q, base_d;
  logic [15:0]       hold_q, hold_d;
  logic [IW-1:0]     num_q, num_d;
  logic              lut_we_q, lut_we_d;
  logic [31:0]       lut_addr_q, lut_addr_d;
  logic [31:0]       lut_data_q, lut_data_d;
  logic [31:0]       freq_q, freq_d;
  logic [15:0]       ampl_q, ampl_d;
  logic              done_q, done_d;

  logic              rd_en, fetch, wrap;
  logic [MOD_AW-1:0] rd_addr;
  logic [15:0]       rd_q;
  logic [15:0]       mod_ram [2**MOD_AW];

  logic signed [31:0] samp_ext, fm_off;
  logic [31:0]        fm_freq;
  logic [15:0]        hold_eff;
  logic [IW-1:0]      num_eff;

  // Write and read use nonblocking updates, so a same-cycle collision reads the old word.
  always_ff @(posedge clk) begin
    if (mod_we) mod_ram[mod_addr] <= mod_data;
    if (rd_en)  rd_q <= mod_ram[rd_addr];
  end

  assign wrap     = (idx_q == num_q);
  assign rd_addr  = wrap ? '0 : idx_q[MOD_AW-1:0];
  assign samp_ext = {{16{rd_q[15]}}, rd_q};
  assign fm_off   = samp_ext >>> FM_SHIFT;
  assign fm_freq  = base_q + $unsigned(fm_off);
  assign hold_eff = (hold_cycles == 16'd0) ? 16'd1 : hold_cycles;
  assign num_eff  = (num_samples == '0) ? {1'b1, {MOD_AW{1'b0}}} : num_samples;

  always_comb begin
    state_d      = state_q;
    lut_cnt_d    = lut_cnt_q;
    load_full_d  = load_full_q;
    lut_loaded_d = lut_loaded_q;
    idx_d        = idx_q;
    hold_cnt_d   = hold_cnt_q;
    fin_d        = fin_q;
    mode_d       = mode_q;
    base_d       = base_q;
    hold_d       = hold_q;
    num_d        = num_q;
    lut_we_d     = 1'b0;
    lut_addr_d   = lut_addr_q;
    lut_data_d   = lut_data_q;
    freq_d       = freq_q;
    ampl_d       = ampl_q;
    done_d       = 1'b0;
    rd_en        = 1'b0;
    fetch        = 1'b0;

    unique case (state_q)
      StIdle: begin
        freq_d = base_freq;
        ampl_d = AmplFull;
        if (load_start) begin
          state_d      = StLoad;
          lut_cnt_d    = '0;
          load_full_d  = 1'b0;
          lut_loaded_d = 1'b0;
        end else if (start && lut_loaded_q) begin
          state_d = StFetch;
          idx_d   = '0;
          fin_d   = 1'b0;
          mode_d  = mode;
          base_d  = base_freq;
          hold_d  = hold_eff;
          num_d   = num_eff;
        end
      end
      StLoad: begin
        freq_d = base_freq;
        ampl_d = AmplFull;
        if (load_full_q) begin
          state_d      = StIdle;
          lut_loaded_d = 1'b1;
        end else if (lut_valid) begin
          lut_we_d   = 1'b1;
          lut_addr_d = 32'(lut_cnt_q);
          lut_data_d = {16'h0000, lut_data};
          lut_cnt_d  = lut_cnt_q + LUT_AW'(1);
          if (lut_cnt_q == '1) load_full_d = 1'b1;
        end
      end
      StFetch: begin
        fetch   = 1'b1;
        state_d = StApply;
      end
      StApply: begin
        if (fin_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
          freq_d  = base_freq;
          ampl_d  = AmplFull;
        end else begin
          if (mode_q == 2'd1) begin
            freq_d = fm_freq;
            ampl_d = AmplFull;
          end else if (mode_q == 2'd2) begin
            freq_d = base_q;
            ampl_d = rd_q;
          end else begin
            freq_d = base_q;
            ampl_d = AmplFull;
          end
          // Single-cycle hold: the next fetch overlaps this apply cycle.
          if (hold_q == 16'd1) begin
            fetch = 1'b1;
          end else begin
            state_d    = StHold;
            hold_cnt_d = hold_q - 16'd1;
          end
        end
      end
      StHold: begin
        if (hold_cnt_q == 16'd1) begin
          fetch   = 1'b1;
          state_d = StApply;
        end else begin
          hold_cnt_d = hold_cnt_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Fetch point: read the next sample, wrap when looping, or mark the run finished.
    if (fetch) begin
      if (wrap && !loop) begin
        fin_d = 1'b1;
      end else begin
        rd_en = 1'b1;
        idx_d = wrap ? IW'(1) : idx_q + IW'(1);
      end
    end

    if (stop && (state_q inside {StFetch, StApply, StHold})) begin
      state_d = StIdle;
      done_d  = 1'b0;
      freq_d  = base_freq;
      ampl_d  = AmplFull;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      lut_cnt_q    <= '0;
      load_full_q  <= 1'b0;
      lut_loaded_q <= 1'b0;
      idx_q        <= '0;
      hold_cnt_q   <= '0;
      fin_q        <= 1'b0;
      mode_q       <= '0;
      base_q       <= '0;
      hold_q       <= '0;
      num_q        <= '0;
      lut_we_q     <= 1'b0;
      lut_addr_q   <= '0;
      lut_data_q   <= '0;
      freq_q       <= '0;
      ampl_q       <= AmplFull;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lut_cnt_q    <= lut_cnt_d;
      load_full_q  <= load_full_d;
      lut_loaded_q <= lut_loaded_d;
      idx_q        <= idx_d;
      hold_cnt_q   <= hold_cnt_d;
      fin_q        <= fin_d;
      mode_q       <= mode_d;
      base_q       <= base_d;
      hold_q       <= hold_d;
      num_q        <= num_d;
      lut_we_q     <= lut_we_d;
      lut_addr_q   <= lut_addr_d;
      lut_data_q   <= lut_data_d;
      freq_q       <= freq_d;
      ampl_q       <= ampl_d;
      done_q       <= done_d;
    end
  end

  assign lut_ready    = (state_q == StLoad) && !load_full_q;
  assign dds_en       = lut_loaded_q;
  assign dds_lut_we   = lut_we_q;
  assign dds_lut_addr = lut_addr_q;
  assign dds_lut_data = lut_data_q;
  assign dds_freq     = freq_q;
  assign dds_ampl     = ampl_q;
  assign lut_loaded   = lut_loaded_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;

endmodule

// File: tb/tb_dds_mod_sequencer.sv
// Directed bench for dds_mod_sequencer: LUT load, FM/AM playback, edge values, reset mid-load.
module tb_dds_mod_sequencer;

  localparam int unsigned LutAw  = 10;
  localparam int unsigned LutLen = 2**LutAw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mod_we;
  logic [7:0]  mod_addr;
  logic [15:0] mod_data;
  logic        load_start;
  logic        lut_valid;
  logic [15:0] lut_data;
  logic        lut_ready;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic        loop;
  logic [31:0] base_freq;
  logic [15:0] hold_cycles;
  logic [8:0]  num_samples;
  logic        dds_en;
  logic        dds_lut_we;
  logic [31:0] dds_lut_addr;
  logic [31:0] dds_lut_data;
  logic [31:0] dds_freq;
  logic [15:0] dds_ampl;
  logic        lut_loaded;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  int lut_err = 0;

  dds_mod_sequencer #(
    .LUT_AW  (LutAw),
    .MOD_AW  (8),
    .FM_SHIFT(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mod_we      (mod_we),
    .mod_addr    (mod_addr),
    .mod_data    (mod_data),
    .load_start  (load_start),
    .lut_valid   (lut_valid),
    .lut_data    (lut_data),
    .lut_ready   (lut_ready),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .loop        (loop),
    .base_freq   (base_freq),
    .hold_cycles (hold_cycles),
    .num_samples (num_samples),
    .dds_en      (dds_en),
    .dds_lut_we  (dds_lut_we),
    .dds_lut_addr(dds_lut_addr),
    .dds_lut_data(dds_lut_data),
    .dds_freq    (dds_freq),
    .dds_ampl    (dds_ampl),
    .lut_loaded  (lut_loaded),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Every LUT write pulse must carry the next address and data == address.
  always @(negedge clk) begin
    if (rst_n && dds_lut_we) begin
      if (dds_lut_addr !== 32'(we_cnt) || dds_lut_data !== {16'h0000, 16'(we_cnt)}) lut_err++;
      we_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 3 == 2) begin
        lut_valid = 1'b0;
        tick();
      end
      lut_valid = 1'b1;
      lut_data  = 16'(i);
      tick();
    end
    lut_valid = 1'b0;
  endtask

  task automatic ram_wr(input logic [7:0] a, input logic [15:0] d);
    mod_we   = 1'b1;
    mod_addr = a;
    mod_data = d;
    tick();
    mod_we   = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_f;
    int          done_seen;

    rst_n = 1'b0; mod_we = 1'b0; mod_addr = '0; mod_data = '0; load_start = 1'b0;
    lut_valid = 1'b0; lut_data = '0; start = 1'b0; stop = 1'b0; mode = 2'd0; loop = 1'b0;
    base_freq = 32'd123; hold_cycles = 16'd1; num_samples = 9'd1;
    #12;
    chk("rst_ampl", dds_ampl, 32'h7FFF);
    chk("rst_freq", dds_freq, 32'h0);
    chk("rst_en", dds_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", lut_ready, 0);
    chk("rst_we", dds_lut_we, 0);
    rst_n = 1'b1;
    tick();

    // Start without a loaded LUT is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("nolut_busy", busy, 0);
    chk("nolut_freq", dds_freq, 32'd123);
    tick();
    chk("nolut_busy2", busy, 0);

    // Full LUT load with valid gaps.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_busy", busy, 1);
    chk("load_ready", lut_ready, 1);
    chk("load_en", dds_en, 0);
    stream(LutLen);
    chk("load_ready_drop", lut_ready, 0);
    chk("load_loaded_late", lut_loaded, 0);
    tick();
    chk("load_loaded", lut_loaded, 1);
    chk("load_dds_en", dds_en, 1);
    chk("load_idle", busy, 0);
    chk("load_we_count", we_cnt, LutLen);
    chk("load_word_err", lut_err, 0);

    // FM playback, 4 samples x 10 clocks.
    ram_wr(8'd0, 16'd4000);
    ram_wr(8'd1, 16'hF060);
    ram_wr(8'd2, 16'hFFFF);
    ram_wr(8'd3, 16'h7FFF);
    mode = 2'd1; base_freq = 32'd30000; hold_cycles = 16'd10; num_samples = 9'd4; loop = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    hold_cycles = 16'd3;
    mode = 2'd2;
    chk("fm_busy", busy, 1);
    chk("fm_pre0", dds_freq, 32'd30000);
    tick();
    chk("fm_pre1", dds_freq, 32'd30000);
    tick();
    done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 10; c++) begin
        case (k)
          0: exp_f = 32'd31000;
          1: exp_f = 32'd29000;
          2: exp_f = 32'd29999;
          default: exp_f = 32'd38191;
        endcase
        chk($sformatf("fm_s%0d_c%0d", k, c), dds_freq, exp_f);
        if (done) done_seen++;
        tick();
      end
    end
    chk("fm_done_during", done_seen, 0);
    chk("fm_done", done, 1);
    chk("fm_revert", dds_freq, 32'd30000);
    chk("fm_idle", busy, 0);
    tick();
    chk("fm_done_1cyc", done, 0);

    // AM with loop, hold 1, stop after 7 cycles.
    ram_wr(8'd0, 16'h8000);
    ram_wr(8'd1, 16'h0000);
    mode = 2'd2; hold_cycles = 16'd1; loop = 1'b1; num_samples = 9'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("am_freq", dds_freq, 32'd30000);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("am_c%0d", c), dds_ampl, (c % 2 == 0) ? 32'h8000 : 32'h0000);
      if (c < 4) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("am_stop_idle", busy, 0);
    chk("am_stop_ampl", dds_ampl, 32'h7FFF);
    chk("am_stop_nodone", done, 0);
    tick();
    chk("am_stop_nodone2", done, 0);

    // hold 0 / num 0 -> 256 one-clock samples; FM wrap past 7FFFFFFF.
    for (int i = 0; i < 256; i++) ram_wr(8'(i), 16'(i * 4));
    mode = 2'd1; base_freq = 32'h7FFF_FFFF; hold_cycles = 16'd0; num_samples = 9'd0;
    loop = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    done_seen = 0;
    for (int k = 0; k < 256; k++) begin
      exp_f = 32'h7FFF_FFFF + 32'(k);
      chk($sformatf("edge_s%0d", k), dds_freq, exp_f);
      if (done) done_seen++;
      tick();
    end
    chk("edge_done_during", done_seen, 0);
    chk("edge_done", done, 1);
    chk("edge_revert", dds_freq, 32'h7FFF_FFFF);

    // load_start beats start; reset mid-load.
    tick();
    we_cnt = 0; lut_err = 0;
    load_start = 1'b1;
    start = 1'b1;
    tick();
    load_start = 1'b0;
    start = 1'b0;
    chk("both_ready", lut_ready, 1);
    chk("both_loaded", lut_loaded, 0);
    chk("both_en", dds_en, 0);
    stream(1000);
    tick();
    chk("mid_we_count", we_cnt, 1000);
    lut_valid = 1'b1;
    lut_data  = 16'd1000;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", dds_lut_we, 0);
    chk("mid_rst_addr", dds_lut_addr, 0);
    chk("mid_rst_loaded", lut_loaded, 0);
    chk("mid_rst_ready", lut_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ampl", dds_ampl, 32'h7FFF);
    lut_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    we_cnt = 0; lut_err = 0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    stream(LutLen);
    tick();
    chk("reload_loaded", lut_loaded, 1);
    chk("reload_we_count", we_cnt, LutLen);
    chk("reload_word_err", lut_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_mod_sequencer.md
Name: dds_mod_sequencer

Overview:
- Sequencer that sits between the host/config logic and the DDS core.
- Streams the 2^LUT_AW-entry sine table into the DDS LUT port after reset.
- Then plays a stored modulation waveform (up to 2^MOD_AW signed samples) into the DDS frequency control (FM) or amplitude control (AM), one sample every hold_cycles clocks.
- Owns dds_en and all DDS control lines, so no other block drives the DDS directly.

Parameters:
- LUT_AW, 16: DDS LUT address width; the load phase writes exactly 2^LUT_AW words.
- MOD_AW, 8: modulation RAM address width (256 samples).
- FM_SHIFT, 2: arithmetic right shift applied to a sample before adding it to base_freq.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mod_we  in  1  write strobe for the internal modulation RAM
- mod_addr  in  MOD_AW  modulation RAM write address
- mod_data  in  16  signed modulation sample
- load_start  in  1  pulse; begin LUT load
- lut_valid  in  1  LUT word valid
- lut_data  in  16  LUT word
- lut_ready  out  1  accepting LUT words
- start  in  1  pulse; begin modulation playback
- stop  in  1  abort playback
- mode  in  2  0=CW, 1=FM, 2=AM, 3=reserved (treated as CW)
- loop  in  1  restart at sample 0 instead of finishing
- base_freq  in  32  signed carrier tuning word
- hold_cycles  in  16  clocks per sample; 0 treated as 1
- num_samples  in  MOD_AW+1  samples to play, 1..2^MOD_AW; 0 treated as 2^MOD_AW
- dds_en  out  1  DDS enable
- dds_lut_we  out  1  DDS LUT write strobe
- dds_lut_addr  out  32  DDS LUT address, zero-extended
- dds_lut_data  out  32  {16'h0000, word}
- dds_freq  out  32  DDS FreqCntrl
- dds_ampl  out  16  DDS AmplCntrl
- lut_loaded  out  1  LUT fully written since reset
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at playback end

Behaviour:
- Reset values: all outputs 0, except dds_ampl=16'h7FFF. State=IDLE. Modulation RAM contents are not reset.
- States: IDLE, LOAD, FETCH, APPLY, HOLD.
- IDLE:
  - dds_freq=base_freq and dds_ampl=16'h7FFF, both registered every cycle.
  - dds_en=lut_loaded.
  - load_start has priority over start when both are asserted.
  - start with lut_loaded=0 is ignored.
- LOAD:
  - Entry clears the word counter and lut_loaded; dds_en=0; lut_ready=1.
  - Each cycle with lut_valid&lut_ready registers {addr=count, data=word}; dds_lut_we pulses for 1 cycle on the next clock edge (latency 1).
  - After word 2^LUT_AW-1 is accepted: lut_ready drops in the same cycle, lut_loaded=1 one cycle later, state returns to IDLE.
  - start and stop are ignored during LOAD.
- FETCH: read modulation RAM[idx] (synchronous read, 1 cycle).
- APPLY: update outputs from the fetched sample s, then go to HOLD with hold counter=hold_cycles-1.
  - FM: dds_freq = base_freq + sign_ext(s >>> FM_SHIFT), with arithmetic (floor) shift and modulo-2^32 wrap; dds_ampl=7FFF.
  - AM: dds_ampl = s; dds_freq=base_freq.
  - CW: no change from the IDLE values.
- Playback timing:
  - start to first applied output: 2 clocks.
  - Each sample is held exactly hold_cycles clocks, including the FETCH/APPLY overhead (FETCH of the next sample overlaps the last hold cycle).
- End of HOLD: idx++.
  - If idx==num_samples and loop=1: idx=0, continue with no gap.
  - If idx==num_samples and loop=0: return to IDLE, done pulses 1 cycle, outputs revert to IDLE values on the same edge.
- stop in FETCH/APPLY/HOLD: go to IDLE on the next edge, no done pulse, outputs revert.
- mode, base_freq, hold_cycles, num_samples are sampled at start; changes mid-run have no effect.
- mod_we is honoured in every state. A write to the address being fetched in the same cycle returns the old data.
- rst_n low mid-LOAD: lut_loaded=0, and a full reload is required.

Test Plan:
1. Reset, then load_start, then stream 65536 words (data=addr[15:0]) with lut_valid gaps every 3rd cycle -> exactly 65536 dds_lut_we pulses with addr 0..65535 and data matching; lut_loaded=1; dds_en=1.
2. FM: base_freq=30000, RAM[0..3]={+4000,-4000,-1,32767}, hold_cycles=10, num_samples=4 -> dds_freq = 31000, 29000, 29999, 38191, each for 10 clocks; done pulses once; dds_freq returns to 30000.
3. AM: RAM[0]=16'h8000, RAM[1]=0, mode=2, hold_cycles=1, loop=1, num_samples=2 -> dds_ampl alternates 8000/0000 every clock; stop after 7 cycles -> IDLE, ampl=7FFF, no done pulse.
4. start before any LUT load -> busy stays 0, outputs unchanged; load_start and start asserted together -> LOAD is entered.
5. Edge values: hold_cycles=0 and num_samples=0 -> 256 samples at 1 clock each; base_freq=32'h7FFFFFFF with s=+4 (FM) -> dds_freq=32'h80000000 (wrap).
6. Assert rst_n low at word 1000 of a load -> all outputs take their reset values immediately and lut_loaded=0; a subsequent full load completes normally.
